// File: rtl/mux_sel_skid.sv
// ---------------------------------------------------------------------------
// mux_sel_skid
//
// Registered N-way selector with a two-entry skid buffer and valid/ready
// handshakes on both sides.
// The input chosen by `sel` is captured on an accepted transfer. It lands in
// the output register, or in the skid register when the output register is
// full and stalled. Data always leaves in the order it was accepted.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_data    N_IN packed inputs, input k at [k*WIDTH +: WIDTH]
//   sel        input index, sampled only on an accepted transfer
//   in_valid   upstream offers a transfer
//   in_ready   stage can accept (registered: low while the skid entry is full)
//   flush      discard both buffered entries and any same-cycle accept
//   out_data   head-of-stage data, straight from the output register
//   out_valid  out_data is valid
//   out_ready  downstream accepts
//   sel_err    one-cycle pulse after an accepted transfer with sel >= N_IN
//   xfer_cnt   saturating count of completed output handshakes
//
// Parameter constraints: 2 <= N_IN <= 16 and 2**SEL_W >= N_IN.
// ---------------------------------------------------------------------------
module mux_sel_skid #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 4,
    parameter int SEL_W = 2,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sel_err,
    output logic [CNT_W-1:0]      xfer_cnt
);

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic             sel_err_q,   sel_err_d;
    logic [CNT_W-1:0] xfer_cnt_q,  xfer_cnt_d;

    logic [WIDTH-1:0] payload;
    logic             sel_hit;
    logic             accept;
    logic             drain;
    logic             out_free;

    // Payload selection. A select with no matching input yields zero and is
    // flagged as out of range.
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path
        // leaves it unassigned; an unassigned path would infer a latch.
        payload = '0;
        sel_hit = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                payload = in_data[k*WIDTH +: WIDTH];
                sel_hit = 1'b1;
            end
        end
    end

    // The skid entry can only be full while the output register is full.
    // That makes "skid empty" exactly "fewer than two entries held".
    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid_q && out_ready;
    assign out_free = !out_valid_q || out_ready;

    always_comb begin
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        sel_err_d    = 1'b0;
        xfer_cnt_d   = xfer_cnt_q;

        // A drain completes downstream even when flush empties the stage.
        if (drain && (xfer_cnt_q != '1)) begin
            xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
        end

        if (flush) begin
            // Buffered data and any same-cycle accept are discarded.
            // out_data keeps its last value.
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            sel_err_d = accept && !sel_hit;
            if (out_free) begin
                if (skid_valid_q) begin
                    // Skid entry moves up first, so it is never overtaken.
                    // in_ready is low here, so no accept can compete.
                    out_data_d   = skid_data_q;
                    out_valid_d  = 1'b1;
                    skid_valid_d = 1'b0;
                end else if (accept) begin
                    out_data_d  = payload;
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else if (accept) begin
                // Output is stalled, so the new entry parks in the skid.
                skid_data_d  = payload;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge values whatever order the statements run in.
        if (reset) begin
            // NOTE: the data registers are reset along with the valid bits.
            // out_data is visible even when out_valid is low, so it must
            // start at a known zero.
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
            sel_err_q    <= 1'b0;
            xfer_cnt_q   <= '0;
        end else begin
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
            sel_err_q    <= sel_err_d;
            xfer_cnt_q   <= xfer_cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_mux_sel_skid.sv
// ---------------------------------------------------------------------------
// tb_mux_sel_skid
//
// Testbench for mux_sel_skid.
// dut_a: 4 inputs, 16-bit counter.
// dut_b: 3 inputs, 4-bit counter. This instance exercises the out-of-range
//        select and counter saturation.
// Both instances share all stimulus.
// ---------------------------------------------------------------------------
module tb_mux_sel_skid;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] in_data;
    logic [95:0]  in_data_b;
    logic [1:0]   sel;
    logic         in_valid;
    logic         flush;
    logic         out_ready;

    logic         a_in_ready, a_out_valid, a_sel_err;
    logic [31:0]  a_out_data;
    logic [15:0]  a_xfer_cnt;
    logic         b_in_ready, b_out_valid, b_sel_err;
    logic [31:0]  b_out_data;
    logic [3:0]   b_xfer_cnt;

    int total = 0;
    int bad   = 0;

    assign in_data_b = in_data[95:0];

    always #5 clk = ~clk;

    mux_sel_skid #(.WIDTH(32), .N_IN(4), .SEL_W(2), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .in_data(in_data), .sel(sel),
        .in_valid(in_valid), .in_ready(a_in_ready), .flush(flush),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .sel_err(a_sel_err), .xfer_cnt(a_xfer_cnt)
    );

    mux_sel_skid #(.WIDTH(32), .N_IN(3), .SEL_W(2), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .in_data(in_data_b), .sel(sel),
        .in_valid(in_valid), .in_ready(b_in_ready), .flush(flush),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .sel_err(b_sel_err), .xfer_cnt(b_xfer_cnt)
    );

    // ---------------- reference model ----------------
    // Each stage is a FIFO of at most two words. The head of the FIFO is the
    // visible output.
    int          m_n_in [2] = '{4, 3};
    int          m_max  [2] = '{65535, 15};
    logic [31:0] mq     [2][$];
    int          m_cnt  [2];
    logic        m_err  [2];
    logic [31:0] m_last [2];

    function automatic logic [31:0] m_payload(int idx);
        if (int'(sel) < m_n_in[idx]) return in_data[int'(sel)*32 +: 32];
        return 32'h0;
    endfunction

    // Applies the cycle rules to the model, using the inputs the DUT samples
    // at the coming edge.
    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                mq[m].delete();
                m_cnt[m]  = 0;
                m_err[m]  = 1'b0;
                m_last[m] = 32'h0;
            end else begin
                bit          acc;
                bit          drn;
                logic [31:0] pl;
                acc = in_valid && (mq[m].size() < 2);
                drn = (mq[m].size() > 0) && out_ready;
                pl  = m_payload(m);
                if (drn && m_cnt[m] < m_max[m]) m_cnt[m]++;
                if (flush) begin
                    mq[m].delete();
                    m_err[m] = 1'b0;
                end else begin
                    m_err[m] = acc && (int'(sel) >= m_n_in[m]);
                    if (drn) void'(mq[m].pop_front());
                    if (acc) mq[m].push_back(pl);
                end
                if (mq[m].size() > 0) m_last[m] = mq[m][0];
            end
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_models();
        check("a.out_valid", 64'(a_out_valid), 64'(mq[0].size() > 0));
        check("a.out_data",  64'(a_out_data),  64'(m_last[0]));
        check("a.in_ready",  64'(a_in_ready),  64'(mq[0].size() < 2));
        check("a.sel_err",   64'(a_sel_err),   64'(m_err[0]));
        check("a.xfer_cnt",  64'(a_xfer_cnt),  64'(m_cnt[0]));
        check("b.out_valid", 64'(b_out_valid), 64'(mq[1].size() > 0));
        check("b.out_data",  64'(b_out_data),  64'(m_last[1]));
        check("b.in_ready",  64'(b_in_ready),  64'(mq[1].size() < 2));
        check("b.sel_err",   64'(b_sel_err),   64'(m_err[1]));
        check("b.xfer_cnt",  64'(b_xfer_cnt),  64'(m_cnt[1]));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_models();
    endtask

    // ---------------- directed vectors for dut_a ----------------
    typedef struct {
        logic [127:0] data;
        logic         iv;
        logic [1:0]   sel;
        logic         ordy;
        logic         fl;
        logic         e_ov;
        logic [31:0]  e_od;
        logic         e_ir;
        logic         e_err;
        logic [15:0]  e_cnt;
    } vec_t;

    function automatic logic [127:0] dat0(input logic [31:0] d0);
        return {32'h33, 32'h22, 32'h11, d0};
    endfunction

    function automatic vec_t mk(input logic [127:0] d, input logic iv, input logic [1:0] s,
                                input logic o, input logic f, input logic ov,
                                input logic [31:0] od, input logic ir, input logic er,
                                input logic [15:0] c);
        vec_t v;
        v.data = d; v.iv = iv; v.sel = s; v.ordy = o; v.fl = f;
        v.e_ov = ov; v.e_od = od; v.e_ir = ir; v.e_err = er; v.e_cnt = c;
        return v;
    endfunction

    vec_t vt [19];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //               data        iv sel or fl | ov od     ir er cnt
        vt[0]  = mk(dat0(32'h00), 1, 2, 1, 0,   1, 32'h22, 1, 0, 0);
        vt[1]  = mk(dat0(32'h00), 0, 0, 1, 0,   0, 32'h22, 1, 0, 1);
        vt[2]  = mk(dat0(32'h00), 1, 0, 1, 0,   1, 32'h00, 1, 0, 1);
        vt[3]  = mk(dat0(32'h00), 1, 1, 1, 0,   1, 32'h11, 1, 0, 2);
        vt[4]  = mk(dat0(32'h00), 1, 2, 1, 0,   1, 32'h22, 1, 0, 3);
        vt[5]  = mk(dat0(32'h00), 1, 3, 1, 0,   1, 32'h33, 1, 0, 4);
        vt[6]  = mk(dat0(32'h00), 0, 0, 1, 0,   0, 32'h33, 1, 0, 5);
        vt[7]  = mk(dat0(32'h0A), 1, 0, 0, 0,   1, 32'h0A, 1, 0, 5);
        vt[8]  = mk(dat0(32'h0B), 1, 0, 0, 0,   1, 32'h0A, 0, 0, 5);
        vt[9]  = mk(dat0(32'h0C), 1, 0, 0, 0,   1, 32'h0A, 0, 0, 5);
        vt[10] = mk(dat0(32'h0C), 0, 0, 1, 0,   1, 32'h0B, 1, 0, 6);
        vt[11] = mk(dat0(32'h0C), 0, 0, 1, 0,   0, 32'h0B, 1, 0, 7);
        vt[12] = mk(dat0(32'h0D), 1, 0, 0, 0,   1, 32'h0D, 1, 0, 7);
        vt[13] = mk(dat0(32'h0E), 1, 0, 0, 0,   1, 32'h0D, 0, 0, 7);
        vt[14] = mk(dat0(32'h0F), 1, 0, 0, 1,   0, 32'h0D, 1, 0, 7);
        vt[15] = mk(dat0(32'h0F), 1, 3, 0, 1,   0, 32'h0D, 1, 0, 7);
        vt[16] = mk(dat0(32'h05), 1, 0, 0, 0,   1, 32'h05, 1, 0, 7);
        vt[17] = mk(dat0(32'h05), 0, 0, 1, 1,   0, 32'h05, 1, 0, 8);
        vt[18] = mk(dat0(32'h05), 0, 0, 1, 0,   0, 32'h05, 1, 0, 8);

        reset = 1'b1; in_data = '0; sel = '0; in_valid = 1'b0;
        flush = 1'b0; out_ready = 1'b0;
        step();
        step();
        check("reset.out_valid", 64'(a_out_valid), 64'd0);
        check("reset.in_ready",  64'(a_in_ready),  64'd1);
        check("reset.out_data",  64'(a_out_data),  64'd0);
        check("reset.xfer_cnt",  64'(a_xfer_cnt),  64'd0);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            in_data = vt[i].data; in_valid = vt[i].iv; sel = vt[i].sel;
            out_ready = vt[i].ordy; flush = vt[i].fl;
            step();
            check($sformatf("vec%0d.out_valid", i), 64'(a_out_valid), 64'(vt[i].e_ov));
            check($sformatf("vec%0d.out_data", i),  64'(a_out_data),  64'(vt[i].e_od));
            check($sformatf("vec%0d.in_ready", i),  64'(a_in_ready),  64'(vt[i].e_ir));
            check($sformatf("vec%0d.sel_err", i),   64'(a_sel_err),   64'(vt[i].e_err));
            check($sformatf("vec%0d.xfer_cnt", i),  64'(a_xfer_cnt),  64'(vt[i].e_cnt));
        end
        flush = 1'b0;

        // Out-of-range select on the 3-input instance.
        in_data = dat0(32'h00); in_valid = 1'b1; sel = 2'd1; out_ready = 1'b1;
        step();
        check("oor.pre_data", 64'(b_out_data), 64'h11);
        sel = 2'd3;
        step();
        check("oor.accepted", 64'(b_out_valid), 64'd1);
        check("oor.data_zero", 64'(b_out_data), 64'd0);
        check("oor.sel_err", 64'(b_sel_err), 64'd1);
        in_valid = 1'b0;
        step();
        check("oor.sel_err_drop", 64'(b_sel_err), 64'd0);

        // Saturation of the 4-bit counter, then reset mid-stream.
        reset = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b1; sel = 2'd0; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("sat.b_cnt", 64'(b_xfer_cnt), 64'd15);
        check("sat.a_cnt", 64'(a_xfer_cnt), 64'd19);
        reset = 1'b1; sel = 2'd3;
        step();
        check("rst.out_valid", 64'(b_out_valid), 64'd0);
        check("rst.in_ready",  64'(b_in_ready),  64'd1);
        check("rst.out_data",  64'(a_out_data),  64'd0);
        check("rst.sel_err",   64'(b_sel_err),   64'd0);
        check("rst.xfer_cnt",  64'(b_xfer_cnt),  64'd0);
        reset = 1'b0;

        // Randomized traffic against the FIFO model.
        for (int i = 0; i < 500; i++) begin
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            sel       = 2'($urandom_range(0, 3));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            reset     = ($urandom_range(0, 79) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_sel_skid.md
Name: mux_sel_skid

Overview:
- Parametrised N-way, W-bit selector that generalises the 2:1 datapath mux into a registered, flow-controlled stage.
- The selected input is captured into a two-entry skid buffer: one output register plus one skid register.
- Both sides use valid/ready handshakes, so the stage can sit between pipeline stages that stall independently.
- Adds flush, out-of-range select detection and a transfer counter.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- N_IN, 4, number of selectable inputs; legal range 2..16.
- SEL_W, 2, select width; must satisfy 2**SEL_W >= N_IN.
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  N_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  index of the input to capture; sampled only on an accepted transfer.
- in_valid  input  1  upstream offers a transfer.
- in_ready  output  1  stage can accept; registered, equals !skid_valid.
- flush  input  1  discard all buffered data.
- out_data  output  WIDTH  head-of-stage data; driven directly from the output register.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts.
- sel_err  output  1  one-cycle pulse the cycle after an accepted transfer with sel >= N_IN.
- xfer_cnt  output  CNT_W  count of completed output handshakes; saturates at all-ones.

Behaviour:
- Reset (synchronous): out_valid=0, skid_valid=0, in_ready=1, out_data=0, skid data=0, sel_err=0, xfer_cnt=0. Reset overrides flush and all handshakes, including a transfer in flight.
- Events: accept = in_valid & in_ready; drain = out_valid & out_ready.
- Payload: in_data slice [sel*WIDTH +: WIDTH] when sel < N_IN; all-zero when sel >= N_IN. An out-of-range transfer is still accepted and sets sel_err=1 on the next cycle only.
- Latency: input to out_data/out_valid is 1 cycle when the output register is free or draining.
- Per-cycle update, in priority order:
  - flush=1: out_valid<=0, skid_valid<=0. Any accept in the same cycle is dropped: no sel_err, no data kept. A drain in the same cycle still counts in xfer_cnt.
  - Output register empty or draining:
    - If skid_valid: out<=skid, skid_valid<=0. This case cannot coincide with accept, because in_ready=0 while skid is full.
    - Else if accept: out<=payload, out_valid<=1.
    - Else: out_valid<=0.
  - Output register full and not draining: if accept, skid<=payload and skid_valid<=1; out is held.
- Ordering: data leaves in acceptance order; the skid entry is never overtaken.
- Full: two entries held means in_ready=0 on the next cycle. Upstream holding in_valid high loses nothing.
- Empty: out_valid=0; out_data keeps its last value; out_ready is ignored.
- Stable output: while out_valid=1 and out_ready=0, out_data and out_valid do not change (except on flush or reset).
- Counter: xfer_cnt increments on every drain and saturates at 2**CNT_W-1 (no wrap). It is cleared only by reset, not by flush.
- sel, in_data, in_valid and out_ready are all don't-care while reset=1.

Test Plan:
- Reset, then in_valid=1, sel=2, in_data={D3=0x33,D2=0x22,D1=0x11,D0=0x00}, out_ready=1 -> next cycle out_valid=1, out_data=0x22, in_ready=1; xfer_cnt=1 one cycle after the handshake.
- Back-to-back streaming with sel cycling 0,1,2,3 and out_ready=1 -> outputs 0x00,0x11,0x22,0x33 on consecutive cycles, in_ready never drops.
- out_ready=0, two accepts of 0xA then 0xB -> in_ready=0 after the second accept; raise out_ready -> 0xA then 0xB on consecutive cycles, then in_ready=1.
- sel=3 with N_IN=3 and in_valid=1 -> transfer accepted, out_data=0, sel_err=1 for exactly one cycle.
- Two entries buffered, flush=1 with in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1, no sel_err, buffered and offered data never appear on out_data.
- CNT_W=4, 17 drains -> xfer_cnt reaches 15 and holds; assert reset mid-stream -> next cycle all outputs at their reset values.
